// File: rtl/fetcher_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Index/tag ranges below are the defaults for a 256-line cache.
package fetcher_pkg;

    localparam int ADDR_W = 32;
    localparam int INS_W  = 32;
    localparam int DATA_W = 32;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [INS_W-1:0]  ins_t;
    typedef logic [DATA_W-1:0] data_t;

    localparam int OPCODE_LO = 0;
    localparam int OPCODE_HI = 6;
    localparam logic [6:0] OPCODE_JAL  = 7'b1101111;
    localparam logic [6:0] OPCODE_BR   = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR = 7'b1100111;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int ICACHE_IDX_LO = 2;
    localparam int ICACHE_IDX_HI = 9;
    localparam int ICACHE_TAG_LO = 10;
    localparam int ICACHE_TAG_HI = 31;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } fetch_state_e;

    // Sequential or predicted-taken successor; wraps modulo 2^32.
    function automatic addr_t next_pc(input addr_t pc, input logic jump, input addr_t imm);
        return jump ? (pc + imm) : (pc + 32'd4);
    endfunction

endpackage

// File: rtl/fetcher_icache.sv
// Direct-mapped instruction cache, one word per line.
// Combinational lookup port, synchronous fill port; only the valid bits are reset.
import fetcher_pkg::*;

module fetcher_icache #(
    parameter int LINES = 256
) (
    input  logic  clk,
    input  logic  rst,
    input  addr_t rd_addr_i,
    output logic  hit_o,
    output data_t data_o,
    input  logic  wr_en_i,
    input  addr_t wr_addr_i,
    input  data_t wr_data_i
);

    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_LO = ICACHE_IDX_LO + IDX_W;
    localparam int TAG_W  = ADDR_W - TAG_LO;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    data_t            data_q [LINES];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [TAG_W-1:0] wr_tag;
    logic             unused_byte_bits;

    assign rd_idx = rd_addr_i[ICACHE_IDX_LO +: IDX_W];
    assign rd_tag = rd_addr_i[ADDR_W-1:TAG_LO];
    assign wr_idx = wr_addr_i[ICACHE_IDX_LO +: IDX_W];
    assign wr_tag = wr_addr_i[ADDR_W-1:TAG_LO];

    // Fetch addresses are word aligned; the byte offset never matters.
    assign unused_byte_bits = ^{rd_addr_i[ICACHE_IDX_LO-1:0], wr_addr_i[ICACHE_IDX_LO-1:0]};

    assign hit_o  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign data_o = data_q[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx] <= TRUE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en_i) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data_i;
        end
    end

endmodule

// File: rtl/fetcher.sv
// Instruction fetch stage: fetch PC, predictor-steered next PC, icache fill
// through the memory controller and one-per-cycle issue to the dispatcher.
//
//   state    | meaning
//   ST_IDLE  | look up pc each cycle; issue on hit, start a fill on miss
//   ST_FETCH | waiting for ok_from_mc; request held on ena/addr_to_mc
import fetcher_pkg::*;

module fetcher #(
    parameter int ICACHE_LINES = 256
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ena_to_mc,
    output logic [31:0] addr_to_mc,
    input  logic        ok_from_mc,
    input  logic [31:0] inst_from_mc,
    output logic [31:0] query_pc,
    output logic [31:0] query_inst,
    input  logic        predicted_jump,
    input  logic [31:0] predicted_imm,
    input  logic        full_from_dsp,
    output logic        ok_to_dsp,
    output logic [31:0] inst_to_dsp,
    output logic [31:0] pc_to_dsp,
    output logic        pred_jump_to_dsp,
    input  logic        rollback_from_rob,
    input  logic [31:0] target_pc_from_rob
);

    fetch_state_e state_q, state_d;
    addr_t        pc_q, pc_d;
    logic         ena_q, ena_d;
    addr_t        addr_q, addr_d;
    logic         ok_q, ok_d;
    ins_t         inst_q, inst_d;
    addr_t        pcd_q, pcd_d;
    logic         pred_q, pred_d;

    logic         cache_hit;
    data_t        cache_data;
    logic         fill_en;

    fetcher_icache #(
        .LINES (ICACHE_LINES)
    ) u_icache (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_i (pc_q),
        .hit_o     (cache_hit),
        .data_o    (cache_data),
        .wr_en_i   (fill_en),
        .wr_addr_i (addr_q),
        .wr_data_i (inst_from_mc)
    );

    assign query_pc   = pc_q;
    assign query_inst = cache_data;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ena_d   = ena_q;
        addr_d  = addr_q;
        ok_d    = FALSE;
        inst_d  = inst_q;
        pcd_d   = pcd_q;
        pred_d  = pred_q;
        fill_en = FALSE;

        case (state_q)
            ST_IDLE: begin
                if (rollback_from_rob) begin
                    pc_d = target_pc_from_rob;
                end else if (full_from_dsp) begin
                    pc_d = pc_q;
                end else if (cache_hit) begin
                    ok_d   = TRUE;
                    inst_d = cache_data;
                    pcd_d  = pc_q;
                    pred_d = predicted_jump;
                    pc_d   = next_pc(pc_q, predicted_jump, predicted_imm);
                end else begin
                    ena_d   = TRUE;
                    addr_d  = pc_q;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // A rollback redirects pc but the fill in flight still lands,
                // since the returned word is correct for addr_q.
                if (rollback_from_rob) begin
                    pc_d = target_pc_from_rob;
                end
                if (ok_from_mc) begin
                    fill_en = TRUE;
                    ena_d   = FALSE;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ena_q   <= FALSE;
            addr_q  <= '0;
            ok_q    <= FALSE;
            inst_q  <= '0;
            pcd_q   <= '0;
            pred_q  <= FALSE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ena_q   <= ena_d;
            addr_q  <= addr_d;
            ok_q    <= ok_d;
            inst_q  <= inst_d;
            pcd_q   <= pcd_d;
            pred_q  <= pred_d;
        end
    end

    assign ena_to_mc        = ena_q;
    assign addr_to_mc       = addr_q;
    assign ok_to_dsp        = ok_q;
    assign inst_to_dsp      = inst_q;
    assign pc_to_dsp        = pcd_q;
    assign pred_jump_to_dsp = pred_q;

endmodule

// File: tb/tb_fetcher.sv
// Bench for fetcher: memory-controller and predictor models plus an issue
// scoreboard; each scenario task pushes the instructions it expects to see.
import fetcher_pkg::*;

module tb_fetcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena_to_mc;
    logic [31:0] addr_to_mc;
    logic        ok_from_mc;
    logic [31:0] inst_from_mc;
    logic [31:0] query_pc;
    logic [31:0] query_inst;
    logic        predicted_jump;
    logic [31:0] predicted_imm;
    logic        full_from_dsp;
    logic        ok_to_dsp;
    logic [31:0] inst_to_dsp;
    logic [31:0] pc_to_dsp;
    logic        pred_jump_to_dsp;
    logic        rollback_from_rob;
    logic [31:0] target_pc_from_rob;

    always #5 clk = ~clk;

    fetcher #(.ICACHE_LINES(256)) dut (
        .clk                (clk),
        .rst                (rst),
        .ena_to_mc          (ena_to_mc),
        .addr_to_mc         (addr_to_mc),
        .ok_from_mc         (ok_from_mc),
        .inst_from_mc       (inst_from_mc),
        .query_pc           (query_pc),
        .query_inst         (query_inst),
        .predicted_jump     (predicted_jump),
        .predicted_imm      (predicted_imm),
        .full_from_dsp      (full_from_dsp),
        .ok_to_dsp          (ok_to_dsp),
        .inst_to_dsp        (inst_to_dsp),
        .pc_to_dsp          (pc_to_dsp),
        .pred_jump_to_dsp   (pred_jump_to_dsp),
        .rollback_from_rob  (rollback_from_rob),
        .target_pc_from_rob (target_pc_from_rob)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] imem [0:511];
    int          mc_lat  = 3;
    int          mc_cnt  = 0;
    int          mc_busy = 0;
    time         mc_ok_time = 0;
    logic        br_taken = 1'b0;

    function automatic logic [31:0] enc_jal(input logic [31:0] imm);
        logic [20:0] m;
        m = imm[20:0];
        return {m[20], m[10:1], m[11], m[19:12], 5'd0, OPCODE_JAL};
    endfunction

    function automatic logic [31:0] enc_beq(input logic [31:0] imm);
        logic [12:0] m;
        m = imm[12:0];
        return {m[12], m[10:5], 5'd0, 5'd0, 3'b000, m[4:1], m[11], OPCODE_BR};
    endfunction

    function automatic exp_t exp_of(input logic [31:0] pc, input logic pred);
        exp_t e;
        e.pc   = pc;
        e.inst = imem[pc[10:2]];
        e.pred = pred;
        return e;
    endfunction

    // Predictor: JAL always taken, branches follow br_taken, everything else falls through.
    always_comb begin
        predicted_jump = 1'b0;
        predicted_imm  = 32'd0;
        if (query_inst[6:0] == OPCODE_JAL) begin
            predicted_jump = 1'b1;
            predicted_imm  = {{12{query_inst[31]}}, query_inst[19:12], query_inst[20],
                              query_inst[30:21], 1'b0};
        end else if (query_inst[6:0] == OPCODE_BR) begin
            predicted_jump = br_taken;
            predicted_imm  = {{20{query_inst[31]}}, query_inst[7], query_inst[30:25],
                              query_inst[11:8], 1'b0};
        end
    end

    // Memory controller: answers mc_lat cycles after a request is seen.
    initial begin
        ok_from_mc   = 1'b0;
        inst_from_mc = 32'd0;
        forever begin
            @(negedge clk);
            ok_from_mc = 1'b0;
            if (rst || !ena_to_mc) begin
                mc_cnt = 0;
            end else begin
                mc_busy++;
                mc_cnt++;
                if (mc_cnt >= mc_lat) begin
                    ok_from_mc   = 1'b1;
                    inst_from_mc = imem[addr_to_mc[10:2]];
                    mc_ok_time   = $time;
                    mc_cnt       = 0;
                end
            end
        end
    end

    // Issue scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && ok_to_dsp) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL issue_unexpected: got pc=%h inst=%h, required no issue", pc_to_dsp, inst_to_dsp);
            end else begin
                e = exp_q.pop_front();
                if ({pc_to_dsp, inst_to_dsp, pred_jump_to_dsp} !== e) begin
                    n_fail++;
                    $display("FAIL issue: got pc=%h inst=%h pred=%b, required pc=%h inst=%h pred=%b",
                             pc_to_dsp, inst_to_dsp, pred_jump_to_dsp, e.pc, e.inst, e.pred);
                end
            end
        end
    end

    task automatic redirect(input logic [31:0] target);
        rollback_from_rob  = 1'b1;
        target_pc_from_rob = target;
        @(negedge clk);
        rollback_from_rob  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; full_from_dsp = 1'b1; rollback_from_rob = 1'b0; target_pc_from_rob = 32'd0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (ena_to_mc !== 1'b0) begin n_fail++; $display("FAIL reset_ena: got %b, required 0", ena_to_mc); end
        n_tests++;
        if (addr_to_mc !== 32'd0) begin n_fail++; $display("FAIL reset_addr: got %h, required 0", addr_to_mc); end
        n_tests++;
        if (ok_to_dsp !== 1'b0) begin n_fail++; $display("FAIL reset_ok: got %b, required 0", ok_to_dsp); end
        n_tests++;
        if ({inst_to_dsp, pc_to_dsp, pred_jump_to_dsp} !== 65'd0) begin
            n_fail++; $display("FAIL reset_issue_regs: got inst=%h pc=%h pred=%b, required 0", inst_to_dsp, pc_to_dsp, pred_jump_to_dsp);
        end
        n_tests++;
        if (query_pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %h, required 0", query_pc); end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (ena_to_mc !== 1'b0) begin n_fail++; $display("FAIL parked_ena: got %b, required 0", ena_to_mc); end
    endtask

    task automatic test_cold_start();
        int k;
        mc_lat = 3;
        exp_q.push_back(exp_of(32'h0, 1'b0));
        full_from_dsp = 1'b0;
        k = 0;
        while (!ena_to_mc && k < 10) begin @(negedge clk); k++; end
        n_tests++;
        if (ena_to_mc !== 1'b1 || addr_to_mc !== 32'h0) begin
            n_fail++; $display("FAIL cold_request: got ena=%b addr=%h, required ena=1 addr=0", ena_to_mc, addr_to_mc);
        end
        k = 0;
        while (!ok_to_dsp && k < 20) begin @(negedge clk); k++; end
        n_tests++;
        if (ok_to_dsp !== 1'b1) begin n_fail++; $display("FAIL cold_issue_timeout: got ok=%b, required 1", ok_to_dsp); end
        n_tests++;
        if ($time - mc_ok_time != 20) begin
            n_fail++; $display("FAIL cold_latency: got %0t after ok_from_mc, required 20", $time - mc_ok_time);
        end
        @(negedge clk);
        n_tests++;
        if (ena_to_mc !== 1'b1 || addr_to_mc !== 32'h4) begin
            n_fail++; $display("FAIL cold_next_request: got ena=%b addr=%h, required ena=1 addr=4", ena_to_mc, addr_to_mc);
        end
        full_from_dsp = 1'b1;
        k = 0;
        while (ena_to_mc && k < 20) begin @(negedge clk); k++; end
        n_tests++;
        if (ena_to_mc !== 1'b0) begin n_fail++; $display("FAIL cold_fill_done: got ena=%b, required 0", ena_to_mc); end
    endtask

    task automatic test_warm_loop();
        int k;
        int busy0;
        redirect(32'h8);
        exp_q.push_back(exp_of(32'h8, 1'b1));
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(exp_of(32'h0, 1'b0));
            exp_q.push_back(exp_of(32'h4, 1'b0));
            exp_q.push_back(exp_of(32'h8, 1'b1));
        end
        full_from_dsp = 1'b0;
        k = 0;
        while (!(ok_to_dsp && pc_to_dsp == 32'h8) && k < 30) begin @(negedge clk); k++; end
        n_tests++;
        if (ok_to_dsp !== 1'b1) begin n_fail++; $display("FAIL warm_first_timeout: got ok=%b, required 1", ok_to_dsp); end
        busy0 = mc_busy;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            n_tests++;
            if (ok_to_dsp !== 1'b1 || ena_to_mc !== 1'b0) begin
                n_fail++; $display("FAIL warm_stream[%0d]: got ok=%b ena=%b, required ok=1 ena=0", i, ok_to_dsp, ena_to_mc);
            end
            if (i == 6) full_from_dsp = 1'b1;
        end
        @(negedge clk);
        n_tests++;
        if (mc_busy != busy0) begin n_fail++; $display("FAIL warm_mc_traffic: got %0d busy cycles, required 0", mc_busy - busy0); end
        n_tests++;
        if (exp_q.size() != 0 || query_pc !== 32'h0) begin
            n_fail++; $display("FAIL warm_end: got %0d pending pc=%h, required 0 pending pc=0", exp_q.size(), query_pc);
        end
    endtask

    task automatic test_backpressure();
        bit [0:9]    pat;
        logic [31:0] hold_pc;
        pat = 10'b0011110000;
        exp_q.push_back(exp_of(32'h0, 1'b0));
        exp_q.push_back(exp_of(32'h4, 1'b0));
        exp_q.push_back(exp_of(32'h8, 1'b1));
        exp_q.push_back(exp_of(32'h0, 1'b0));
        exp_q.push_back(exp_of(32'h4, 1'b0));
        exp_q.push_back(exp_of(32'h8, 1'b1));
        for (int i = 0; i < 10; i++) begin
            full_from_dsp = pat[i];
            hold_pc = query_pc;
            @(negedge clk);
            n_tests++;
            if (ok_to_dsp !== !pat[i]) begin
                n_fail++; $display("FAIL bp_ok[%0d]: got %b, required %b", i, ok_to_dsp, !pat[i]);
            end
            if (pat[i]) begin
                n_tests++;
                if (query_pc !== hold_pc) begin
                    n_fail++; $display("FAIL bp_pc_frozen[%0d]: got %h, required %h", i, query_pc, hold_pc);
                end
            end
        end
        full_from_dsp = 1'b1;
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_lost: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_taken_branch();
        int k;
        br_taken = 1'b1;
        redirect(32'h20);
        n_tests++;
        if (ok_to_dsp !== 1'b0) begin n_fail++; $display("FAIL br_after_rollback: got ok=%b, required 0", ok_to_dsp); end
        exp_q.push_back(exp_of(32'h20, 1'b1));
        exp_q.push_back(exp_of(32'h30, 1'b0));
        full_from_dsp = 1'b0;
        k = 0;
        while (!(ok_to_dsp && pc_to_dsp == 32'h30) && k < 40) begin @(negedge clk); k++; end
        full_from_dsp = 1'b1;
        n_tests++;
        if (ok_to_dsp !== 1'b1 || pc_to_dsp !== 32'h30) begin
            n_fail++; $display("FAIL br_taken_target: got ok=%b pc=%h, required ok=1 pc=00000030", ok_to_dsp, pc_to_dsp);
        end
        br_taken = 1'b0;
        redirect(32'h20);
        exp_q.push_back(exp_of(32'h20, 1'b0));
        exp_q.push_back(exp_of(32'h24, 1'b0));
        full_from_dsp = 1'b0;
        k = 0;
        while (!(ok_to_dsp && pc_to_dsp == 32'h24) && k < 40) begin @(negedge clk); k++; end
        full_from_dsp = 1'b1;
        n_tests++;
        if (ok_to_dsp !== 1'b1 || pc_to_dsp !== 32'h24) begin
            n_fail++; $display("FAIL br_not_taken: got ok=%b pc=%h, required ok=1 pc=00000024", ok_to_dsp, pc_to_dsp);
        end
    endtask

    task automatic test_rollback_miss();
        int k;
        int busy0;
        mc_lat = 6;
        redirect(32'h100);
        exp_q.push_back(exp_of(32'h40, 1'b0));
        full_from_dsp = 1'b0;
        k = 0;
        while (!(ena_to_mc && addr_to_mc == 32'h100) && k < 10) begin @(negedge clk); k++; end
        redirect(32'h40);
        n_tests++;
        if (ena_to_mc !== 1'b1 || addr_to_mc !== 32'h100 || query_pc !== 32'h40 || ok_to_dsp !== 1'b0) begin
            n_fail++; $display("FAIL rb_in_fetch: got ena=%b addr=%h pc=%h ok=%b, required ena=1 addr=00000100 pc=00000040 ok=0",
                               ena_to_mc, addr_to_mc, query_pc, ok_to_dsp);
        end
        k = 0;
        while (!(ok_to_dsp && pc_to_dsp == 32'h40) && k < 40) begin @(negedge clk); k++; end
        full_from_dsp = 1'b1;
        n_tests++;
        if (ok_to_dsp !== 1'b1 || pc_to_dsp !== 32'h40) begin
            n_fail++; $display("FAIL rb_target_issue: got ok=%b pc=%h, required ok=1 pc=00000040", ok_to_dsp, pc_to_dsp);
        end
        redirect(32'h100);
        exp_q.push_back(exp_of(32'h100, 1'b0));
        full_from_dsp = 1'b0;
        busy0 = mc_busy;
        @(negedge clk);
        full_from_dsp = 1'b1;
        n_tests++;
        if (ok_to_dsp !== 1'b1 || ena_to_mc !== 1'b0 || mc_busy != busy0) begin
            n_fail++; $display("FAIL rb_line_filled: got ok=%b ena=%b, required ok=1 ena=0 (hit)", ok_to_dsp, ena_to_mc);
        end
    endtask

    task automatic test_reset_mid_fetch();
        int k;
        mc_lat = 1000;
        redirect(32'h200);
        full_from_dsp = 1'b0;
        k = 0;
        while (!ena_to_mc && k < 10) begin @(negedge clk); k++; end
        n_tests++;
        if (ena_to_mc !== 1'b1) begin n_fail++; $display("FAIL rst_fetch_start: got ena=%b, required 1", ena_to_mc); end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (ena_to_mc !== 1'b0 || query_pc !== 32'h0 || ok_to_dsp !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_fetch: got ena=%b pc=%h ok=%b, required ena=0 pc=0 ok=0", ena_to_mc, query_pc, ok_to_dsp);
        end
        rst = 1'b0;
        mc_lat = 2;
        k = 0;
        while (!ena_to_mc && k < 5) begin @(negedge clk); k++; end
        full_from_dsp = 1'b1;
        n_tests++;
        if (ena_to_mc !== 1'b1 || addr_to_mc !== 32'h0) begin
            n_fail++; $display("FAIL rst_refetch: got ena=%b addr=%h, required ena=1 addr=0", ena_to_mc, addr_to_mc);
        end
        k = 0;
        while (ena_to_mc && k < 10) begin @(negedge clk); k++; end
        n_tests++;
        if (ena_to_mc !== 1'b0) begin n_fail++; $display("FAIL rst_refill_done: got ena=%b, required 0", ena_to_mc); end
    endtask

    initial begin
        rst = 1'b1;
        full_from_dsp = 1'b1;
        rollback_from_rob = 1'b0;
        target_pc_from_rob = 32'd0;
        for (int i = 0; i < 512; i++) imem[i] = {12'(i), 20'h00013};
        imem[2] = enc_jal(32'hFFFF_FFF8);
        imem[8] = enc_beq(32'd16);

        test_reset();
        test_cold_start();
        test_warm_loop();
        test_backpressure();
        test_taken_branch();
        test_rollback_miss();
        test_reset_mid_fetch();

        repeat (3) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL final_pending: got %0d, required 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit reached, required self-termination");
        $fatal(1);
    end

endmodule
